// File: rtl/haar_lifting_mac.sv
// Haar lifting arithmetic stage: one (even, odd) pixel pair in, one
// (low, high) coefficient pair out, three cycles later. Row/column and pixel
// pointers ride along with the data. High-band clamp events are counted.
module haar_lifting_mac #(
  parameter int WIDTH       = 256,
  parameter int HIGH_OFFSET = 128,
  parameter int ROUNDING    = 1,
  parameter int SAT_CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              i_mac,
  input  logic                     i_mac_valid,
  input  logic [$clog2(WIDTH)-1:0] i_mac_row_column_pointer,
  input  logic [$clog2(WIDTH)-1:0] i_mac_pixel_pointer,
  input  logic                     i_clear_stats,
  output logic [15:0]              o_mac,
  output logic                     o_mac_valid,
  output logic [$clog2(WIDTH)-1:0] o_mac_row_column_pointer,
  output logic [$clog2(WIDTH)-1:0] o_mac_pixel_pointer,
  output logic [SAT_CNT_W-1:0]     o_sat_count,
  output logic                     o_sat_flag
);

  localparam int PW = $clog2(WIDTH);

  // Rounding constant, in the widths used by the low and high paths.
  localparam logic [8:0]         RND_L = (ROUNDING != 0) ? 9'd1 : 9'd0;
  localparam logic signed [10:0] RND_H = (ROUNDING != 0) ? 11'sd1 : 11'sd0;
  localparam logic signed [10:0] OFS_H = 11'(HIGH_OFFSET);
  localparam logic [SAT_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SAT_CNT_W-1:0] CNT_ONE = SAT_CNT_W'(1);

  // Stage 1 registers
  logic          v1;
  logic [7:0]    a1, b1;
  logic [PW-1:0] rc1, px1;

  // Stage 2 registers
  logic                v2;
  logic [8:0]          sum2;
  logic signed [8:0]   diff2;
  logic [PW-1:0]       rc2, px2;

  // Stage 3 combinational results
  logic [7:0]          lo;
  logic [7:0]          hi;
  logic signed [10:0]  diff_ext;
  logic signed [10:0]  ht;
  logic                clamp;
  logic                sat_evt;

  // Stage 1: capture the pair and its pointers; data only on valid cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      a1  <= 8'd0;
      b1  <= 8'd0;
      rc1 <= '0;
      px1 <= '0;
    end else begin
      v1 <= i_mac_valid;
      if (i_mac_valid) begin
        a1  <= i_mac[15:8];
        b1  <= i_mac[7:0];
        rc1 <= i_mac_row_column_pointer;
        px1 <= i_mac_pixel_pointer;
      end
    end
  end

  // Stage 2: 9-bit unsigned sum and 9-bit signed difference of the pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      sum2  <= 9'd0;
      diff2 <= 9'sd0;
      rc2   <= '0;
      px2   <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        sum2  <= {1'b0, a1} + {1'b0, b1};
        diff2 <= $signed({1'b0, a1}) - $signed({1'b0, b1});
        rc2   <= rc1;
        px2   <= px1;
      end
    end
  end

  // Stage 3 math: halve with optional rounding, bias and clamp the high band.
  always_comb begin
    lo       = 8'((sum2 + RND_L) >> 1);
    diff_ext = {{2{diff2[8]}}, diff2};
    ht       = ((diff_ext + RND_H) >>> 1) + OFS_H;
    clamp    = 1'b0;
    hi       = 8'd0;
    if (ht < 11'sd0) begin
      hi    = 8'd0;
      clamp = 1'b1;
    end else if (ht > 11'sd255) begin
      hi    = 8'd255;
      clamp = 1'b1;
    end else begin
      hi    = ht[7:0];
      clamp = 1'b0;
    end
    sat_evt = v2 & clamp;
  end

  // Stage 3 registers: outputs hold their last value across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_mac_valid              <= 1'b0;
      o_mac                    <= 16'd0;
      o_mac_row_column_pointer <= '0;
      o_mac_pixel_pointer      <= '0;
    end else begin
      o_mac_valid <= v2;
      if (v2) begin
        o_mac                    <= {lo, hi};
        o_mac_row_column_pointer <= rc2;
        o_mac_pixel_pointer      <= px2;
      end
    end
  end

  // Saturating clamp counter and sticky flag; a clear beats a same-cycle event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_sat_count <= '0;
      o_sat_flag  <= 1'b0;
    end else if (i_clear_stats) begin
      o_sat_count <= '0;
      o_sat_flag  <= 1'b0;
    end else if (sat_evt) begin
      if (o_sat_count != CNT_MAX) begin
        o_sat_count <= o_sat_count + CNT_ONE;
      end
      o_sat_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_haar_lifting_mac.sv
// Scoreboard bench for haar_lifting_mac: three instances (default,
// truncating, 4-bit counter) share one random stimulus stream; a monitor
// compares every cycle against an arithmetic reference model.
module tb_haar_lifting_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_mac;
  logic        i_mac_valid;
  logic [7:0]  i_rc, i_px;
  logic        i_clear_stats;

  logic [15:0] mac1, mac0, mac4;
  logic        val1, val0, val4;
  logic [7:0]  rc1, rc0, rc4, px1, px0, px4;
  logic [15:0] cnt1_o, cnt0_o;
  logic [3:0]  cnt4_o;
  logic        flg1, flg0, flg4;

  haar_lifting_mac dut (
    .clk(clk), .rst(rst), .i_mac(i_mac), .i_mac_valid(i_mac_valid),
    .i_mac_row_column_pointer(i_rc), .i_mac_pixel_pointer(i_px),
    .i_clear_stats(i_clear_stats), .o_mac(mac1), .o_mac_valid(val1),
    .o_mac_row_column_pointer(rc1), .o_mac_pixel_pointer(px1),
    .o_sat_count(cnt1_o), .o_sat_flag(flg1));

  haar_lifting_mac #(.ROUNDING(0)) dut_r0 (
    .clk(clk), .rst(rst), .i_mac(i_mac), .i_mac_valid(i_mac_valid),
    .i_mac_row_column_pointer(i_rc), .i_mac_pixel_pointer(i_px),
    .i_clear_stats(i_clear_stats), .o_mac(mac0), .o_mac_valid(val0),
    .o_mac_row_column_pointer(rc0), .o_mac_pixel_pointer(px0),
    .o_sat_count(cnt0_o), .o_sat_flag(flg0));

  haar_lifting_mac #(.SAT_CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .i_mac(i_mac), .i_mac_valid(i_mac_valid),
    .i_mac_row_column_pointer(i_rc), .i_mac_pixel_pointer(i_px),
    .i_clear_stats(i_clear_stats), .o_mac(mac4), .o_mac_valid(val4),
    .o_mac_row_column_pointer(rc4), .o_mac_pixel_pointer(px4),
    .o_sat_count(cnt4_o), .o_sat_flag(flg4));

  always #5 clk = ~clk;

  typedef struct {
    int     a;
    int     b;
    int     rc;
    int     px;
    longint due;
  } exp_t;

  exp_t   q[$];
  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  logic   clr_s = 1'b0;
  bit     mon_en = 1'b0;

  // Model state: last delivered coefficients/pointers and expected stats.
  int e_mac1 = 0, e_mac0 = 0, e_rc = 0, e_px = 0;
  int e_cnt1 = 0, e_cnt0 = 0, e_cnt4 = 0;
  int e_flg1 = 0, e_flg0 = 0, e_flg4 = 0;

  task automatic chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: returns {clamp, L[7:0], H[7:0]} using plain integer arithmetic.
  function automatic int ref_pair(int a, int b, int rnd);
    int l, d, h, c;
    l = (a + b + rnd) / 2;
    d = a - b + rnd;
    h = (d >= 0) ? d / 2 : -((1 - d) / 2);
    h = h + 128;
    c = 0;
    if (h > 255) begin h = 255; c = 1; end
    if (h < 0)   begin h = 0;   c = 1; end
    return (c << 16) | (l << 8) | h;
  endfunction

  function automatic int sat_inc(int v, int max);
    return (v < max) ? v + 1 : v;
  endfunction

  // Cycle counter and the clear value the DUT samples at each edge.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    clr_s <= i_clear_stats;
  end

  // Monitor: pops expected results when due and checks all outputs each cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      bit ev;
      int r1, r0;
      exp_t e;
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("valid", val1, ev);
      chk("valid_r0", val0, ev);
      chk("valid_c4", val4, ev);
      r1 = 0;
      r0 = 0;
      if (ev) begin
        e = q.pop_front();
        r1 = ref_pair(e.a, e.b, 1);
        r0 = ref_pair(e.a, e.b, 0);
        e_mac1 = r1 & 16'hFFFF;
        e_mac0 = r0 & 16'hFFFF;
        e_rc = e.rc;
        e_px = e.px;
      end
      if (clr_s) begin
        e_cnt1 = 0; e_cnt0 = 0; e_cnt4 = 0;
        e_flg1 = 0; e_flg0 = 0; e_flg4 = 0;
      end else if (ev) begin
        if (r1[16]) begin
          e_cnt1 = sat_inc(e_cnt1, 65535); e_flg1 = 1;
          e_cnt4 = sat_inc(e_cnt4, 15);    e_flg4 = 1;
        end
        if (r0[16]) begin
          e_cnt0 = sat_inc(e_cnt0, 65535); e_flg0 = 1;
        end
      end
      chk("mac", mac1, e_mac1);
      chk("mac_r0", mac0, e_mac0);
      chk("mac_c4", mac4, e_mac1);
      chk("rc_ptr", rc1, e_rc);
      chk("px_ptr", px1, e_px);
      chk("rc_ptr_r0", rc0, e_rc);
      chk("px_ptr_c4", px4, e_px);
      chk("sat_count", cnt1_o, e_cnt1);
      chk("sat_count_r0", cnt0_o, e_cnt0);
      chk("sat_count_c4", cnt4_o, e_cnt4);
      chk("sat_flag", flg1, e_flg1);
      chk("sat_flag_r0", flg0, e_flg0);
      chk("sat_flag_c4", flg4, e_flg4);
    end
  end

  task automatic step(bit v, int a, int b, int rc, int px, bit clr);
    exp_t e;
    @(negedge clk);
    i_mac_valid   = v;
    i_mac         = {8'(a), 8'(b)};
    i_rc          = 8'(rc);
    i_px          = 8'(px);
    i_clear_stats = clr;
    if (v) begin
      e.a = a; e.b = b; e.rc = rc; e.px = px; e.due = cyc + 3;
      q.push_back(e);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_mac"}, mac1, 0);
    chk({tag, "_valid"}, val1, 0);
    chk({tag, "_rc"}, rc1, 0);
    chk({tag, "_px"}, px1, 0);
    chk({tag, "_cnt"}, cnt1_o, 0);
    chk({tag, "_flag"}, flg1, 0);
    chk({tag, "_mac_r0"}, mac0, 0);
    chk({tag, "_cnt_c4"}, cnt4_o, 0);
  endtask

  initial begin
    rst = 1'b1;
    i_mac = 16'd0;
    i_mac_valid = 1'b0;
    i_rc = 8'd0;
    i_px = 8'd0;
    i_clear_stats = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    mon_en = 1'b1;

    // Directed pairs, including both clamp corners.
    step(1'b1, 200, 100, 3, 10, 1'b0);
    step(1'b1, 100, 200, 3, 12, 1'b0);
    step(1'b1, 0, 0, 4, 0, 1'b0);
    step(1'b1, 255, 0, 5, 2, 1'b0);
    step(1'b1, 0, 255, 6, 4, 1'b0);
    idle(4);

    // Long back-to-back stream, a 2-cycle gap, then four more pairs.
    for (int i = 0; i < 256; i++)
      step(1'b1, $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 255), i, 1'b0);
    idle(2);
    for (int i = 0; i < 4; i++)
      step(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 7, i, 1'b0);
    idle(4);

    // Three clamps, then a fourth whose stats update collides with a clear.
    for (int i = 0; i < 3; i++) step(1'b1, 255, 0, 1, i, 1'b0);
    step(1'b1, 255, 0, 1, 3, 1'b0);
    step(1'b0, 0, 0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 0, 0, 1'b1);
    idle(4);

    // Random mix with bubbles, extreme samples and occasional clears.
    for (int i = 0; i < 80; i++) begin
      int a, b;
      a = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
      b = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
      step($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 15) == 0);
    end
    idle(4);

    // Twenty clamps: the 4-bit counter must stick at its maximum.
    for (int i = 0; i < 20; i++) step(1'b1, 255, 0, 9, i, 1'b0);
    idle(4);

    // Reset while two pairs are in flight.
    step(1'b1, 10, 20, 2, 2, 1'b0);
    step(1'b1, 30, 40, 2, 4, 1'b0);
    @(negedge clk);
    i_mac_valid = 1'b0;
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    chk_zero("rst_hold");
    rst = 1'b0;
    q.delete();
    e_mac1 = 0; e_mac0 = 0; e_rc = 0; e_px = 0;
    e_cnt1 = 0; e_cnt0 = 0; e_cnt4 = 0;
    e_flg1 = 0; e_flg0 = 0; e_flg4 = 0;
    @(posedge clk);
    mon_en = 1'b1;
    idle(6);

    // A final pair after reset to show the pipeline still works.
    step(1'b1, 200, 100, 3, 10, 1'b0);
    idle(5);
    chk("drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/haar_lifting_mac.md
Name: haar_lifting_mac

Overview:
- Arithmetic stage between the DWT control/memory sequencer's read port and its write-back port.
- Takes one pixel pair per cycle (even/odd sample of a row or column) and produces one Haar low-pass/high-pass coefficient pair.
- The row/column and pixel pointers travel through the pipeline alongside the data, so the sequencer can compute write addresses directly from this block's outputs.
- Fully pipelined, no stalls; adds saturation monitoring for the high band.

Parameters:
- WIDTH, 256, image dimension; pointer width is $clog2(WIDTH).
- HIGH_OFFSET, 128, unsigned bias added to high-pass coefficient to map it into 0..255.
- ROUNDING, 1, 1 = add 1 before each >>1; 0 = truncate (floor).
- SAT_CNT_W, 16, width of saturation event counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_mac  in  16  pixel pair; [15:8] = even sample a, [7:0] = odd sample b, both unsigned.
- i_mac_valid  in  1  pair valid this cycle.
- i_mac_row_column_pointer  in  $clog2(WIDTH)  row/column index of the pair.
- i_mac_pixel_pointer  in  $clog2(WIDTH)  index of sample a (even).
- i_clear_stats  in  1  synchronous clear of o_sat_count and o_sat_flag.
- o_mac  out  16  coefficients; [15:8] = L (low band), [7:0] = H (high band).
- o_mac_valid  out  1  o_mac and pointers valid.
- o_mac_row_column_pointer  out  $clog2(WIDTH)  delayed copy of input pointer.
- o_mac_pixel_pointer  out  $clog2(WIDTH)  delayed copy of input pointer.
- o_sat_count  out  SAT_CNT_W  number of H clamp events.
- o_sat_flag  out  1  sticky: any clamp since reset/clear.

Behaviour:
- Reset (async assert, deassert synchronous to clk): all outputs 0; all pipeline valid bits 0; in-flight data discarded.
- Fixed latency 3 cycles: i_mac_valid at edge N gives o_mac_valid at edge N+3. One result per cycle; no backpressure.
- Stage 1: register a, b, valid, and both pointers.
- Stage 2: sum = a + b (9-bit unsigned); diff = a - b (9-bit signed, range -255..255). Pointers and valid pass through.
- Stage 3, with r = ROUNDING ? 1 : 0:
  - L = (sum + r) >> 1. Result is 0..255, so no clamp is needed.
  - Ht = ((diff + r) >>> 1) + HIGH_OFFSET, computed at 11 bits signed.
  - H = clamp(Ht, 0, 255). Assert sat_evt when clamping occurs and the stage-2 valid is 1.
- Data and pointer registers load only when the corresponding stage valid is 1. During bubbles, o_mac and the pointers hold their last values and o_mac_valid = 0.
- o_mac_valid is a pure delay of i_mac_valid, not gated by anything else.
- Saturation counter:
  - Increments on sat_evt and saturates at all-ones (no wrap).
  - o_sat_flag is set on sat_evt.
  - Both registered; they update in the same cycle that the clamped o_mac appears.
- i_clear_stats:
  - Zeroes the counter and flag at the next edge.
  - If sat_evt occurs in the same cycle, clear wins: result is 0, and the event is lost.
- Pointers are not interpreted; any value passes through unchanged, including the last-pair pointer used by the sequencer for mode switching.
- Back-to-back valids across row/column boundaries and decomposition levels need no special handling.

Test Plan:
- Reset then a=200, b=100, ptr=(rc 3, px 10), ROUNDING=1 -> 3 cycles later: o_mac_valid=1, o_mac=16'h96B2 (L=150, H=178), pointers 3/10; o_sat_count=0.
- a=100, b=200 -> L=150, H=78 (16'h964E). a=b=0 -> 16'h0080.
- a=255, b=0, ROUNDING=1 -> Ht=256 clamps to 255; L=128; o_mac=16'h80FF; o_sat_count=1, o_sat_flag=1.
- Same input with ROUNDING=0 -> L=127, H=255 with no clamp; count stays 0.
- a=0, b=255, ROUNDING=0 -> H=0 with no clamp, L=127.
- Stream 256 consecutive pairs with incrementing px, then a 2-cycle gap, then 4 more pairs -> outputs appear in order with exact 3-cycle latency, gap reproduced on o_mac_valid, o_mac held during the gap.
- Force 3 clamp events, then assert i_clear_stats in the same cycle as a 4th clamp -> count=0, flag=0.
- Separately, with SAT_CNT_W=4, apply 20 clamps -> count holds at 15.
- Assert rst asynchronously while 2 valid pairs are in flight -> outputs go to 0 immediately, and no o_mac_valid appears after deassertion.
